passcode_entry: RTL and testbench
=================================

# passcode_entry

Keypad front-end for the door lock, upstream of the lock controller. It collects a digit sequence framed by start and end strobes and compares it against the stored passcode. It emits a one-cycle unlock or fail result and enforces a timed lockout after repeated failures. It also exposes the entered digits for the 7-segment display path.

## Interface

Parameters:
- CODE_LEN, 4: number of digits in a valid code (1..6).
- DEFAULT_CODE, 24'h001234: stored code, BCD, right-aligned, low CODE_LEN nibbles used.
- MAX_FAIL, 3: consecutive failures that trigger lockout (1..7).
- LOCK_CYCLES, 1000: lockout duration in clk cycles.
- TIMEOUT, 5000: idle cycles in ENTRY before the entry is abandoned.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ps_start  in  1  one-cycle strobe, begins an entry.
- ps_num  in  4  digit value, sampled only when key_valid=1.
- key_valid  in  1  one-cycle strobe, ps_num holds a key press.
- ps_end  in  1  one-cycle strobe, ends an entry and requests a check.
- unlock  out  1  one-cycle pulse on a correct code.
- fail  out  1  one-cycle pulse on a wrong code.
- locked  out  1  high for the whole lockout period.
- busy  out  1  high while in ENTRY or CHECK.
- digit_cnt  out  3  digits accepted in the current entry.
- entry_digits  out  24  accepted digits, BCD; newest in [3:0], older digits shifted up.

## Operation

- States: IDLE, ENTRY, CHECK, LOCKOUT.
- IDLE:
  - ps_start -> ENTRY; clear entry_digits, digit_cnt, overflow flag and idle timer.
  - key_valid and ps_end are ignored.
- ENTRY:
  - key_valid with ps_num<=9 and digit_cnt<6: shift the digit in, increment digit_cnt, reset idle timer.
  - ps_num>=10: the press is ignored and does not reset the idle timer.
  - A valid digit when digit_cnt==6, or a digit beyond CODE_LEN: sets the sticky overflow flag. The buffer is not shifted past 6 digits.
  - ps_start: restarts the entry, clearing as from IDLE.
  - ps_end -> CHECK.
  - Idle timer reaches TIMEOUT -> IDLE silently. No fail pulse; fail count unchanged.
  - Priority within one cycle: ps_start > ps_end > key_valid. A digit arriving with ps_end is dropped.
- CHECK (exactly one cycle):
  - Match = (digit_cnt==CODE_LEN) and !overflow and (low CODE_LEN nibbles of entry_digits == DEFAULT_CODE).
  - Match: unlock pulse, fail count := 0, -> IDLE.
  - Mismatch: fail pulse, fail count +1. If the new count equals MAX_FAIL -> LOCKOUT with the lock timer loaded to LOCK_CYCLES-1; otherwise -> IDLE.
  - entry_digits and digit_cnt hold their values until the next ps_start.
- LOCKOUT:
  - All inputs are ignored.
  - locked=1; the timer decrements each cycle.
  - At 0 -> IDLE; fail count := 0; locked drops.
- Fail count is 3 bits and saturates; it never wraps.

## Timing

- Reset (rst=0, asynchronous): state IDLE.
  - unlock=0, fail=0, locked=0, busy=0, digit_cnt=0, entry_digits=0.
  - Fail count, overflow flag and all timers are cleared.
- Reset mid-entry or mid-lockout aborts immediately. No result pulse is produced.
- All outputs are registered.
- ps_end sampled at edge N: CHECK during cycle N+1; unlock or fail high during cycle N+2 for exactly one cycle.
- locked rises in the same cycle as the fail pulse that triggers lockout. It stays high for exactly LOCK_CYCLES cycles.
- A ps_start in the first IDLE cycle after a result is accepted, so back-to-back entries are possible.
- busy is high from the cycle after ps_start through the CHECK cycle.
- A digit is visible on entry_digits and digit_cnt one cycle after its key_valid.

## Test plan

- Reset, ps_start, digits 1,2,3,4, ps_end -> unlock high exactly 2 cycles after ps_end for one cycle; fail stays 0; digit_cnt=4; entry_digits=24'h001234.
- ps_start, digits 1,2,3,5, ps_end, repeated 3 times -> fail pulse on each attempt. The third fail coincides with locked rising; locked stays high 1000 cycles. ps_start during lockout is ignored.
- ps_start, digits 1,2,3,4,9, ps_end -> overflow gives a fail pulse. ps_num=4'hA mid-entry is ignored, digit_cnt unchanged.
- ps_start, digits 1,2, then 5000 idle cycles -> returns to IDLE with busy=0 and no fail pulse. A following correct entry unlocks.
- Same cycle: ps_end and key_valid(4) after digits 1,2,3 -> digit dropped, fail pulse. Same cycle: ps_start and ps_end mid-entry -> entry restarts, digit_cnt=0, no result pulse.
- rst asserted during lockout and during ENTRY -> all outputs 0 immediately, fail count 0. The next correct code unlocks.

Source files
------------

// File: rtl/passcode_entry.sv
// Keypad passcode front-end: collects a framed digit sequence, checks it against the
// stored code, pulses unlock/fail and holds a timed lockout after repeated failures.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for ps_start; last entry stays visible on the display
// S_ENTRY   | collecting digits, idle timer running
// S_CHECK   | single cycle comparing the entry against the stored code
// S_LOCKOUT | all inputs ignored until the lock timer expires
module passcode_entry #(
  parameter int          CODE_LEN     = 4,
  parameter logic [23:0] DEFAULT_CODE = 24'h001234,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCK_CYCLES  = 1000,
  parameter int          TIMEOUT      = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_start,
  input  logic [3:0]  ps_num,
  input  logic        key_valid,
  input  logic        ps_end,
  output logic        unlock,
  output logic        fail,
  output logic        locked,
  output logic        busy,
  output logic [2:0]  digit_cnt,
  output logic [23:0] entry_digits
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [23:0]       CODE_MASK  = 24'hFFFFFF >> (4 * (6 - CODE_LEN));
  localparam logic [23:0]       CODE_REF   = DEFAULT_CODE & CODE_MASK;
  localparam logic [2:0]        CODE_LEN_C = 3'(CODE_LEN);
  localparam logic [2:0]        MAX_FAIL_C = 3'(MAX_FAIL);
  localparam logic [2:0]        MAX_DIGITS = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_LOCKOUT
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       digits_q, digits_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [IDLE_W-1:0] idle_tmr_q, idle_tmr_d;
  logic [LOCK_W-1:0] lock_tmr_q, lock_tmr_d;
  logic [2:0]        fail_cnt_q, fail_cnt_d;
  logic              unlock_q, unlock_d;
  logic              fail_q, fail_d;
  logic              locked_q, locked_d;
  logic              busy_q, busy_d;

  logic       digit_ok;
  logic       code_match;
  logic [2:0] fail_inc;

  assign digit_ok   = key_valid && (ps_num <= 4'd9);
  assign code_match = (cnt_q == CODE_LEN_C) && !ovf_q && ((digits_q & CODE_MASK) == CODE_REF);
  assign fail_inc   = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      idle_tmr_q <= '0;
      lock_tmr_q <= '0;
      fail_cnt_q <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      idle_tmr_q <= idle_tmr_d;
      lock_tmr_q <= lock_tmr_d;
      fail_cnt_q <= fail_cnt_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    idle_tmr_d = idle_tmr_q;
    lock_tmr_d = lock_tmr_q;
    fail_cnt_d = fail_cnt_q;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ps_start) begin
          state_d    = S_ENTRY;
          digits_d   = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          idle_tmr_d = IDLE_LOAD;
        end
      end

      S_ENTRY: begin
        if (ps_start) begin
          digits_d   = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          idle_tmr_d = IDLE_LOAD;
        end else if (ps_end) begin
          state_d = S_CHECK;
        end else if (digit_ok && (cnt_q < MAX_DIGITS)) begin
          digits_d   = {digits_q[19:0], ps_num};
          cnt_d      = cnt_q + 3'd1;
          idle_tmr_d = IDLE_LOAD;
          if (cnt_q >= CODE_LEN_C) ovf_d = 1'b1;
        end else begin
          // A full buffer still records the extra digit, but only real shifts count as activity.
          if (digit_ok) ovf_d = 1'b1;
          if (idle_tmr_q == '0) begin
            state_d = S_IDLE;
          end else begin
            idle_tmr_d = idle_tmr_q - IDLE_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (code_match) begin
          unlock_d   = 1'b1;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_inc;
          if (fail_inc == MAX_FAIL_C) begin
            state_d    = S_LOCKOUT;
            lock_tmr_d = LOCK_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_tmr_q == '0) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - LOCK_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    locked_d = (state_d == S_LOCKOUT);
    busy_d   = (state_d == S_ENTRY) || (state_d == S_CHECK);
  end

  assign unlock       = unlock_q;
  assign fail         = fail_q;
  assign locked       = locked_q;
  assign busy         = busy_q;
  assign digit_cnt    = cnt_q;
  assign entry_digits = digits_q;

endmodule

// File: tb/tb_passcode_entry.sv
// Bench for passcode_entry: vector table, hand-written corner sequences and random
// stimulus, all cross-checked every cycle against a queue-based reference model.
module tb_passcode_entry;

  localparam int          CODE_LEN     = 4;
  localparam logic [23:0] DEFAULT_CODE = 24'h001234;
  localparam int          MAX_FAIL     = 3;
  localparam int          LOCK_CYCLES  = 1000;
  localparam int          TIMEOUT      = 5000;
  localparam int          CODE_REF     = int'(DEFAULT_CODE) % (1 << (4 * CODE_LEN));

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps_start = 1'b0;
  logic [3:0]  ps_num = 4'h0;
  logic        key_valid = 1'b0;
  logic        ps_end = 1'b0;
  logic        unlock, fail, locked, busy;
  logic [2:0]  digit_cnt;
  logic [23:0] entry_digits;

  passcode_entry #(
    .CODE_LEN(CODE_LEN), .DEFAULT_CODE(DEFAULT_CODE), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ps_start(ps_start), .ps_num(ps_num), .key_valid(key_valid),
    .ps_end(ps_end), .unlock(unlock), .fail(fail), .locked(locked), .busy(busy),
    .digit_cnt(digit_cnt), .entry_digits(entry_digits)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: entry as a queue of digits plus plain counters.
  bit m_active, m_checking, m_unlock, m_fail;
  int m_digits[$];
  int m_presses, m_idle, m_lock_left, m_fails;

  function automatic void model_reset();
    m_active = 0; m_checking = 0; m_unlock = 0; m_fail = 0;
    m_digits.delete();
    m_presses = 0; m_idle = 0; m_lock_left = 0; m_fails = 0;
  endfunction

  function automatic int code_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic void model_step(input bit st, input bit kv, input int num, input bit en);
    m_unlock = 0;
    m_fail = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_checking) begin
      m_checking = 0;
      if (m_presses == CODE_LEN && code_value() == CODE_REF) begin
        m_unlock = 1;
        m_fails = 0;
      end else begin
        m_fail = 1;
        if (m_fails < 7) m_fails++;
        if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYCLES;
      end
    end else if (st) begin
      m_active = 1;
      m_digits.delete();
      m_presses = 0;
      m_idle = 0;
    end else if (m_active) begin
      if (en) begin
        m_active = 0;
        m_checking = 1;
      end else begin
        if (kv && num <= 9) m_presses++;
        if (kv && num <= 9 && m_digits.size() < 6) begin
          m_digits.push_back(num);
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) m_active = 0;
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_pack();
    int v = code_value();
    return {1'b0, m_unlock, m_fail, m_lock_left > 0, m_active || m_checking,
            3'(m_digits.size()), 24'(v)};
  endfunction

  function automatic logic [31:0] dut_pack();
    return {1'b0, unlock, fail, locked, busy, digit_cnt, entry_digits};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic kv, input logic [3:0] num, input logic en);
    ps_start = st; key_valid = kv; ps_num = num; ps_end = en;
    @(posedge clk);
    #1;
    model_step(st, kv, int'(num), en);
    ps_start = 1'b0; key_valid = 1'b0; ps_num = 4'h0; ps_end = 1'b0;
    check("model", dut_pack(), model_pack());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("reset_async", dut_pack(), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    check("reset_hold", dut_pack(), model_pack());
  endtask

  // Full entry of n digits (oldest in the highest used nibble), then check the result pulse.
  task automatic enter(input int n, input logic [23:0] code, input bit exp_unlock, input string name);
    logic [23:0] c = code;
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < n; i++) step(0, 1, c[4*(n-1-i) +: 4], 0);
    step(0, 0, 4'h0, 1);
    check({name, "_check_cycle"}, 32'({unlock, fail}), 32'h0);
    step(0, 0, 4'h0, 0);
    check(name, 32'({unlock, fail}), exp_unlock ? 32'h2 : 32'h1);
  endtask

  typedef struct packed {
    logic        st;
    logic        kv;
    logic [3:0]  num;
    logic        en;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic kv, input logic [3:0] num, input logic en,
                              input logic u, input logic f, input logic b,
                              input logic [2:0] c, input logic [23:0] d);
    return {st, kv, num, en, {1'b0, u, f, 1'b0, b, c, d}};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    int          lk;
    logic        st, kv, en;
    logic [3:0]  num;
    logic [23:0] dc = DEFAULT_CODE;

    //               st kv num  en  u  f  b  cnt  digits
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 1, 3'd0, 24'h0));
    tbl.push_back(mk(0, 1, 4'h1, 0, 0, 0, 1, 3'd1, 24'h1));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 1, 3'd2, 24'h12));
    tbl.push_back(mk(0, 1, 4'h3, 0, 0, 0, 1, 3'd3, 24'h123));
    tbl.push_back(mk(0, 1, 4'hA, 0, 0, 0, 1, 3'd3, 24'h123));
    tbl.push_back(mk(0, 1, 4'h4, 0, 0, 0, 1, 3'd4, 24'h1234));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 3'd4, 24'h1234));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0, 3'd4, 24'h1234));
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 1, 3'd0, 24'h0));
    tbl.push_back(mk(0, 1, 4'h1, 0, 0, 0, 1, 3'd1, 24'h1));
    tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 1, 3'd2, 24'h12));
    tbl.push_back(mk(0, 1, 4'h3, 0, 0, 0, 1, 3'd3, 24'h123));
    tbl.push_back(mk(0, 1, 4'h4, 1, 0, 0, 1, 3'd3, 24'h123));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0, 3'd3, 24'h123));
    tbl.push_back(mk(1, 0, 4'h0, 0, 0, 0, 1, 3'd0, 24'h0));
    tbl.push_back(mk(0, 1, 4'h5, 0, 0, 0, 1, 3'd1, 24'h5));
    tbl.push_back(mk(1, 0, 4'h0, 1, 0, 0, 1, 3'd0, 24'h0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 3'd0, 24'h0));
    tbl.push_back(mk(0, 1, 4'h9, 0, 0, 0, 1, 3'd1, 24'h9));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 1, 3'd1, 24'h9));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0, 3'd1, 24'h9));
    tbl.push_back(mk(0, 1, 4'h7, 0, 0, 0, 0, 3'd1, 24'h9));
    tbl.push_back(mk(0, 0, 4'h0, 1, 0, 0, 0, 3'd1, 24'h9));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].kv, tbl[i].num, tbl[i].en);
      check($sformatf("table_%0d", i), dut_pack(), tbl[i].exp);
    end

    // Three wrong codes: lockout of exactly LOCK_CYCLES cycles, starts ignored meanwhile.
    do_reset();
    enter(4, 24'h1235, 0, "wrong_1");
    enter(4, 24'h1235, 0, "wrong_2");
    enter(4, 24'h1235, 0, "wrong_3");
    check("lock_rise", 32'({fail, locked}), 32'h3);
    lk = 1;
    for (int i = 0; i < LOCK_CYCLES + 50; i++) begin
      step((i % 97) == 5, 1, 4'h1, 0);
      if (!locked) break;
      lk++;
    end
    check("lock_length", 32'(lk), 32'(LOCK_CYCLES));
    check("lock_start_ignored", 32'(busy), 32'h0);
    enter(4, 24'h1234, 1, "unlock_after_lock");

    // Overflow digit turns a correct prefix into a failure.
    enter(5, 24'h12349, 0, "overflow");
    check("overflow_cnt", 32'(digit_cnt), 32'h5);

    // Idle timeout leaves ENTRY silently after exactly TIMEOUT idle cycles.
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h1, 0);
    step(0, 1, 4'h2, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 4'h0, 0);
    check("timeout_still_busy", 32'(busy), 32'h1);
    step(0, 0, 4'h0, 0);
    check("timeout_exit", 32'({busy, fail}), 32'h0);
    step(0, 0, 4'h0, 0);
    check("timeout_no_fail", 32'(fail), 32'h0);
    enter(4, 24'h1234, 1, "unlock_after_timeout");

    // Reset mid-entry clears the fail count: two fails plus one more must not lock.
    enter(2, 24'h0099, 0, "pre_reset_1");
    enter(2, 24'h0099, 0, "pre_reset_2");
    step(1, 0, 4'h0, 0);
    step(0, 1, 4'h1, 0);
    step(0, 1, 4'h2, 0);
    do_reset();
    enter(4, 24'h9999, 0, "post_reset_fail");
    check("failcnt_cleared", 32'(locked), 32'h0);
    enter(4, 24'h1234, 1, "unlock_after_entry_reset");

    // Reset during lockout.
    enter(1, 24'h0, 0, "lk_1");
    enter(1, 24'h0, 0, "lk_2");
    enter(1, 24'h0, 0, "lk_3");
    for (int i = 0; i < 20; i++) step(0, 0, 4'h0, 0);
    check("locked_before_reset", 32'(locked), 32'h1);
    do_reset();
    enter(4, 24'h1234, 1, "unlock_after_lock_reset");

    // Random traffic, biased toward the correct digits so unlocks occur too.
    for (int i = 0; i < 4000; i++) begin
      st = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 11) == 0);
      kv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 7 && m_digits.size() < CODE_LEN)
        num = dc[4*(CODE_LEN-1-m_digits.size()) +: 4];
      else
        num = 4'($urandom_range(0, 11));
      step(st, kv, num, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
